// File: rtl/logic_unit_pkg.sv
// Shared encodings for the chunk-serial logic unit: op codes, FSM states and
// the beat-counter width helper.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-beat configuration still needs a 1-bit counter.
  function automatic int beat_bits(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_serial_chunk.sv
// Combinational CHUNK-wide slice of the logic unit: applies the op and reports
// whether the produced slice is all zeros or all ones.
module logic_chunk
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [CHUNK-1:0] o_res,
  output logic             o_zero,
  output logic             o_ones
);

  always_comb begin
    o_res = '0;
    case (i_op)
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = ~(i_a | i_b);
    endcase
    o_zero = (o_res == '0);
    o_ones = &o_res;
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Chunk-serial AND/OR/XOR/NOR unit: latches operands, processes CHUNK bits per
// clock and presents result plus zero/ones flags on a valid/ready output.
module logic_unit_serial
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds its data until it sees ready, and a sink's ready
  // has no effect while valid is low.

  localparam int NBEATS = WIDTH / CHUNK;
  localparam int BW     = beat_bits(NBEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [BW-1:0]    r_beat;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ones;

  logic             w_accept;
  logic             w_busy;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_res_slice;
  logic             w_slice_zero;
  logic             w_slice_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)            w_next = ST_BUSY;
      ST_BUSY: if (r_beat == LAST_BEAT) w_next = ST_DONE;
      ST_DONE: if (out_ready)           w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    w_accept  = in_valid && (r_state == ST_IDLE);
    w_busy    = (r_state == ST_BUSY);
  end

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (r_beat == BW'(i)) begin
        w_a_slice = r_a[i*CHUNK +: CHUNK];
        w_b_slice = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  logic_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_op   (r_op),
    .o_res  (w_res_slice),
    .o_zero (w_slice_zero),
    .o_ones (w_slice_ones)
  );

  // The beat counter parks on the last beat through DONE; the next accept
  // clears it, so it never runs past NBEATS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_AND;
      r_beat   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ones   <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_beat <= '0;
      r_zero <= 1'b1;
      r_ones <= 1'b1;
    end else if (w_busy) begin
      for (int i = 0; i < NBEATS; i++) begin
        if (r_beat == BW'(i)) r_result[i*CHUNK +: CHUNK] <= w_res_slice;
      end
      r_zero <= r_zero & w_slice_zero;
      r_ones <= r_ones & w_slice_ones;
      if (r_beat != LAST_BEAT) r_beat <= r_beat + BW'(1);
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign ones      = r_ones;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_logic_unit_serial.sv
// Directed bench for logic_unit_serial at 32/8 plus a lockstep parameter sweep
// over (32,32), (32,1) and (64,16).
module tb_logic_unit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ones;
  logic [1:0]  state_dbg;

  logic        s_in_valid;
  logic [63:0] s_a;
  logic [63:0] s_b;
  logic [1:0]  s_op;
  logic        s_out_ready;
  logic        d1_ir, d1_ov, d1_z, d1_o;
  logic        d2_ir, d2_ov, d2_z, d2_o;
  logic        d3_ir, d3_ov, d3_z, d3_o;
  logic [31:0] d1_res;
  logic [31:0] d2_res;
  logic [63:0] d3_res;
  logic [1:0]  d1_st, d2_st, d3_st;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ones(ones), .state_dbg(state_dbg)
  );

  logic_unit_serial #(.WIDTH(32), .CHUNK(32)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d1_ir),
    .a(s_a[31:0]), .b(s_b[31:0]), .op(s_op), .out_valid(d1_ov), .out_ready(s_out_ready),
    .result(d1_res), .zero(d1_z), .ones(d1_o), .state_dbg(d1_st)
  );

  logic_unit_serial #(.WIDTH(32), .CHUNK(1)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d2_ir),
    .a(s_a[31:0]), .b(s_b[31:0]), .op(s_op), .out_valid(d2_ov), .out_ready(s_out_ready),
    .result(d2_res), .zero(d2_z), .ones(d2_o), .state_dbg(d2_st)
  );

  logic_unit_serial #(.WIDTH(64), .CHUNK(16)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d3_ir),
    .a(s_a), .b(s_b), .op(s_op), .out_valid(d3_ov), .out_ready(s_out_ready),
    .result(d3_res), .zero(d3_z), .ones(d3_o), .state_dbg(d3_st)
  );

  function automatic logic [63:0] ref_logic(input logic [63:0] x, input logic [63:0] y,
                                            input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Driver: present one operation and return just after the accepting edge.
  task automatic drive_accept(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vo);
    a = va; b = vb; op = vo; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Driver: count cycles after acceptance until out_valid, bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (result !== 32'h0)   begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_vec++; if (zero !== 1'b0)      begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero); end
    n_vec++; if (ones !== 1'b0)      begin n_err++; $display("FAIL reset_ones got=%b exp=0", ones); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_or();
    int cnt;
    drive_accept(32'hF0F0_0000, 32'h0F0F_0000, 2'b01);
    wait_valid(cnt);
    n_vec++; if (cnt !== 4)               begin n_err++; $display("FAIL or_latency got=%0d exp=4", cnt); end
    n_vec++; if (result !== 32'hFFFF_0000) begin n_err++; $display("FAIL or_result got=%h exp=ffff0000", result); end
    n_vec++; if (zero !== 1'b0)           begin n_err++; $display("FAIL or_zero got=%b exp=0", zero); end
    n_vec++; if (ones !== 1'b0)           begin n_err++; $display("FAIL or_ones got=%b exp=0", ones); end
    release_result();
    n_vec++; if (in_ready !== 1'b1)       begin n_err++; $display("FAIL or_release got=%b exp=1", in_ready); end
  endtask

  task automatic test_xor_nor();
    int cnt;
    drive_accept(32'h1234_5678, 32'h1234_5678, 2'b10);
    wait_valid(cnt);
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL xor_result got=%h exp=0", result); end
    n_vec++; if (zero !== 1'b1)    begin n_err++; $display("FAIL xor_zero got=%b exp=1", zero); end
    n_vec++; if (ones !== 1'b0)    begin n_err++; $display("FAIL xor_ones got=%b exp=0", ones); end
    release_result();
    drive_accept(32'h0, 32'h0, 2'b11);
    wait_valid(cnt);
    n_vec++; if (cnt !== 4)                begin n_err++; $display("FAIL nor_latency got=%0d exp=4", cnt); end
    n_vec++; if (result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL nor_result got=%h exp=ffffffff", result); end
    n_vec++; if (ones !== 1'b1)            begin n_err++; $display("FAIL nor_ones got=%b exp=1", ones); end
    n_vec++; if (zero !== 1'b0)            begin n_err++; $display("FAIL nor_zero got=%b exp=0", zero); end
    release_result();
  endtask

  task automatic test_hold();
    int cnt;
    drive_accept(32'hFFFF_FFFF, 32'h0000_FFFF, 2'b00);
    // Disturb the inputs while the unit is busy.
    a = 32'h0; b = 32'h0; op = 2'b11; in_valid = 1'b1;
    wait_valid(cnt);
    in_valid = 1'b0;
    n_vec++; if (cnt !== 4) begin n_err++; $display("FAIL hold_latency got=%0d exp=4", cnt); end
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (result !== 32'h0000_FFFF) begin n_err++; $display("FAIL hold_result[%0d] got=%h exp=0000ffff", k, result); end
      n_vec++; if (zero !== 1'b0 || ones !== 1'b0) begin n_err++; $display("FAIL hold_flags[%0d] got=%b%b exp=00", k, zero, ones); end
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL hold_hs[%0d] got ir=%b ov=%b exp ir=0 ov=1", k, in_ready, out_valid); end
      @(posedge clk); #1;
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    logic [31:0] res[2];
    int nacc = 0;
    int nres = 0;
    logic acc_now;
    acc_cyc[0] = 0; acc_cyc[1] = 0; res[0] = '0; res[1] = '0;
    out_ready = 1'b1;
    a = 32'hFF00_FF00; b = 32'h0F0F_0F0F; op = 2'b00; in_valid = 1'b1;
    for (int k = 0; k < 40 && (nacc < 2 || nres < 2); k++) begin
      acc_now = 1'b0;
      if (out_valid && nres < 2) begin res[nres] = result; nres++; end
      if (in_ready && in_valid && nacc < 2) begin acc_cyc[nacc] = cyc + 1; acc_now = 1'b1; end
      @(posedge clk); #1;
      if (acc_now) begin
        nacc++;
        if (nacc == 1) begin a = 32'h1200_0034; b = 32'h0034_1200; op = 2'b01; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (nacc !== 2 || acc_cyc[1] - acc_cyc[0] !== 6) begin n_err++; $display("FAIL b2b_interval got=%0d exp=6 (accepts=%0d)", acc_cyc[1] - acc_cyc[0], nacc); end
    n_vec++; if (res[0] !== 32'h0F00_0F00) begin n_err++; $display("FAIL b2b_and got=%h exp=0f000f00", res[0]); end
    n_vec++; if (res[1] !== 32'h1234_1234) begin n_err++; $display("FAIL b2b_or got=%h exp=12341234", res[1]); end
  endtask

  task automatic test_reset_busy();
    int seen;
    drive_accept(32'hAAAA_AAAA, 32'h5555_5555, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rstbusy_state got=%0d exp=0", state_dbg); end
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rstbusy_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (result !== 32'h0)   begin n_err++; $display("FAIL rstbusy_result got=%h exp=0", result); end
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rstbusy_no_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_sweep();
    logic [63:0] exp64;
    logic [31:0] exp32;
    int l1, l2, l3, cnt;
    for (int it = 0; it < 6; it++) begin
      s_a = {$urandom, $urandom};
      s_b = {$urandom, $urandom};
      s_op = 2'($urandom_range(0, 3));
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      exp64 = ref_logic(s_a, s_b, s_op);
      exp32 = exp64[31:0];
      l1 = 0; l2 = 0; l3 = 0; cnt = 0;
      while ((l1 == 0 || l2 == 0 || l3 == 0) && cnt < 80) begin
        @(posedge clk); #1;
        cnt++;
        if (d1_ov && l1 == 0) l1 = cnt;
        if (d2_ov && l2 == 0) l2 = cnt;
        if (d3_ov && l3 == 0) l3 = cnt;
      end
      n_vec++; if (l1 !== 1)  begin n_err++; $display("FAIL sweep32x32_lat[%0d] got=%0d exp=1", it, l1); end
      n_vec++; if (l2 !== 32) begin n_err++; $display("FAIL sweep32x1_lat[%0d] got=%0d exp=32", it, l2); end
      n_vec++; if (l3 !== 4)  begin n_err++; $display("FAIL sweep64x16_lat[%0d] got=%0d exp=4", it, l3); end
      n_vec++; if (d1_res !== exp32) begin n_err++; $display("FAIL sweep32x32_res[%0d] got=%h exp=%h", it, d1_res, exp32); end
      n_vec++; if (d2_res !== exp32) begin n_err++; $display("FAIL sweep32x1_res[%0d] got=%h exp=%h", it, d2_res, exp32); end
      n_vec++; if (d3_res !== exp64) begin n_err++; $display("FAIL sweep64x16_res[%0d] got=%h exp=%h", it, d3_res, exp64); end
      n_vec++; if (d3_z !== (exp64 == 64'h0) || d3_o !== (&exp64)) begin n_err++; $display("FAIL sweep64x16_flags[%0d] got=%b%b exp=%b%b", it, d3_z, d3_o, exp64 == 64'h0, &exp64); end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 2'b00;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_op = 2'b00;
    test_reset();
    @(posedge clk); #1;
    test_or();
    test_xor_nor();
    test_hold();
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_busy();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Parametrised, chunk-serial bitwise logic unit: the successor to the fixed 32-bit OR array. It applies one of AND/OR/XOR/NOR to two WIDTH-bit operands, CHUNK bits per clock, and reports zero/all-ones flags alongside the result. It sits beside the ALU datapath and trades latency for area, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NBEATS, derived, equal to WIDTH/CHUNK; not overridable.
- Reset is asynchronous and active-low.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0; meaningful only while out_valid.
- ones  out  1  result == all ones; meaningful only while out_valid.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid is high, latch a, b and op, set beat=0, zero_acc=1, ones_acc=1, and go to BUSY.
- BUSY: in_ready=0.
  - Each cycle, write result[beat*CHUNK +: CHUNK] = op(a_q, b_q) on that slice.
  - zero_acc &= (slice == 0); ones_acc &= (slice == all ones).
  - beat increments by 1. On beat == NBEATS-1, write the last slice, go to DONE, and set out_valid.
- DONE: out_valid=1; result, zero and ones are held stable. When out_ready is high, go to IDLE and clear out_valid.
- Bits of result outside written slices keep their old value during BUSY; consumers must ignore result unless out_valid is high.
- Input changes after acceptance have no effect, because operands are latched.
- in_valid during BUSY or DONE is not accepted. The source must hold its data until in_ready is high.
- out_ready high while out_valid is low has no effect.
- All four op codes are defined; there is no illegal encoding.
- Beat counter width: clog2(NBEATS), minimum 1 bit. The counter never exceeds NBEATS-1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, ones=0, beat=0.
- Acceptance at edge T0. Slices are written at edges T1..TN, where N=NBEATS. out_valid is high from edge TN onwards.
- Latency: in_valid & in_ready to out_valid = NBEATS cycles.
- Release: out_valid & out_ready at edge TD → IDLE. in_ready is high from TD. The next accept is at TD+1 at the earliest.
- Minimum issue interval: NBEATS+2 cycles with out_ready held high.
- CHUNK == WIDTH: NBEATS=1, so BUSY lasts one cycle and latency is 1.
- Reset asserted in any state: outputs return to reset values immediately (asynchronous). A partial result is discarded and no out_valid is produced.
- Reset deassertion is synchronised externally. The first accept is possible on the first edge after release.

## Structure
- Package logic_unit_pkg holds:
  - the op encoding localparams: OP_AND, OP_OR, OP_XOR, OP_NOR;
  - the state encoding: ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module logic_chunk: combinational, CHUNK-wide. Inputs are the a/b slices and op; outputs are the result slice plus slice_zero and slice_ones. It is instantiated once and fed by a beat-indexed slice mux.
- The top level holds the FSM, beat counter, operand latches, result register and flag accumulators.

## Test plan
- Reset with WIDTH=32, CHUNK=8 → in_ready=1, out_valid=0, result=0. Assert rst_n=0 mid-BUSY → state returns to IDLE, and no out_valid follows.
- a=0xF0F0_0000, b=0x0F0F_0000, op=OR → out_valid exactly 4 cycles after accept, result=0xFFFF_0000, zero=0, ones=0.
- a=0x1234_5678, b=0x1234_5678, op=XOR → result=0, zero=1, ones=0. a=0, b=0, op=NOR → result=0xFFFF_FFFF, ones=1.
- Hold out_ready=0 for 5 cycles after out_valid → result and flags stay stable and in_ready stays 0. Toggle a, b and in_valid during BUSY → the result is unaffected.
- Back-to-back AND then OR with out_ready tied high → the second accept lands 6 cycles after the first (NBEATS+2), and both results are correct.
- Sweep parameters (WIDTH,CHUNK) = (32,32), (32,1) and (64,16) with random operands and ops against a reference model → latency equals NBEATS and results match.
